// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end for a 64 KB SRAM built as 2 banks x 4 byte lanes x 8K entries.
// Address phases become SRAM reads straight away. Writes are issued in the following data
// phase, when hwdata is valid. A read that collides with a pending write is stalled for one cycle.
module ahb_slave_if (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  input  logic [7:0]  sram_q0,
  input  logic [7:0]  sram_q1,
  input  logic [7:0]  sram_q2,
  input  logic [7:0]  sram_q3,
  input  logic [7:0]  sram_q4,
  input  logic [7:0]  sram_q5,
  input  logic [7:0]  sram_q6,
  input  logic [7:0]  sram_q7,
  output logic        sram_w_en,
  output logic [12:0] sram_addr_out,
  output logic [31:0] sram_wdata,
  output logic [3:0]  bank0_csn,
  output logic [3:0]  bank1_csn
);

  // Address-phase context, carried into the data phase
  logic [15:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        bank_q, bank_d;
  logic        wpend_q, wpend_d;
  logic        rpend_q, rpend_d;

  logic        req;
  logic        stall;
  logic        accepted;
  logic        rd_act;
  logic        wr_act;
  logic        active;
  logic        sel_bank;
  logic [3:0]  wmask;
  logic [3:0]  lane_en;

  // Upper address bits alias into the 64 KB window. The burst type is not used,
  // because every beat is handled as an independent transfer.
  logic        unused_bits;
  assign unused_bits = ^{haddr[31:16], hburst, addr_q[15]};

  // The transfer is a valid NONSEQ/SEQ beat aimed at this slave.
  assign req      = hsel & hready & htrans[1];
  // The write data phase owns the SRAM port, so a read address phase has to wait one cycle.
  assign stall    = wpend_q & req & ~hwrite;
  assign accepted = req & ~stall;

  assign hready_resp = ~stall;
  assign hresp       = 2'b00;

  // Next-state values of the data-phase context
  always_comb begin
    addr_d  = haddr[15:0];
    size_d  = hsize;
    bank_d  = haddr[15];
    wpend_d = accepted & hwrite;
    rpend_d = accepted & ~hwrite;
  end

  // Register the context with a synchronous active-low reset.
  // Reset drops any transfer that is in flight.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      addr_q  <= '0;
      size_q  <= '0;
      bank_q  <= 1'b0;
      wpend_q <= 1'b0;
      rpend_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      bank_q  <= bank_d;
      wpend_q <= wpend_d;
      rpend_q <= rpend_d;
    end
  end

  // Byte-lane mask of the pending write. Sizes above word are treated as word.
  always_comb begin
    wmask = 4'b1111;
    case (size_q)
      3'd0: wmask = 4'b0001 << addr_q[1:0];
      3'd1: wmask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wmask = 4'b1111;
    endcase
  end

  // A pending write takes priority. Otherwise an accepted read uses the port in its address phase.
  assign wr_act   = wpend_q;
  assign rd_act   = accepted & ~hwrite & ~wpend_q;
  assign active   = wr_act | rd_act;
  assign sel_bank = wr_act ? bank_q : haddr[15];
  assign lane_en  = wr_act ? wmask : 4'b1111;

  // SRAM address, write enable and write data
  always_comb begin
    sram_w_en     = 1'b1;
    sram_addr_out = haddr[14:2];
    sram_wdata    = hwdata;
    if (wr_act) begin
      sram_w_en     = 1'b0;
      sram_addr_out = addr_q[14:2];
    end
  end

  // Per-lane active-low chip selects for both banks
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_csn
      assign bank0_csn[gi] = ~(active & ~sel_bank & lane_en[gi]);
      assign bank1_csn[gi] = ~(active &  sel_bank & lane_en[gi]);
    end
  endgenerate

  // Read data from the bank addressed in the previous cycle.
  // The bus sees zero when no read is pending.
  always_comb begin
    hrdata = 32'h0;
    if (rpend_q) begin
      hrdata = bank_q ? {sram_q7, sram_q6, sram_q5, sram_q4}
                      : {sram_q3, sram_q2, sram_q1, sram_q0};
    end
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if.
// Expected SRAM writes and read data are queued when stimulus is driven.
// They are popped and compared in the cycle where the DUT should produce them.
module tb_ahb_slave_if;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [7:0]  sram_q0, sram_q1, sram_q2, sram_q3;
  logic [7:0]  sram_q4, sram_q5, sram_q6, sram_q7;
  logic        sram_w_en;
  logic [12:0] sram_addr_out;
  logic [31:0] sram_wdata;
  logic [3:0]  bank0_csn;
  logic [3:0]  bank1_csn;

  ahb_slave_if dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .htrans(htrans), .hready(hready), .hwdata(hwdata),
    .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
    .sram_q0(sram_q0), .sram_q1(sram_q1), .sram_q2(sram_q2), .sram_q3(sram_q3),
    .sram_q4(sram_q4), .sram_q5(sram_q5), .sram_q6(sram_q6), .sram_q7(sram_q7),
    .sram_w_en(sram_w_en), .sram_addr_out(sram_addr_out), .sram_wdata(sram_wdata),
    .bank0_csn(bank0_csn), .bank1_csn(bank1_csn)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    int          due;
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  b0;
    logic [3:0]  b1;
  } wexp_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge hclk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
  endtask

  task automatic push_wr(input logic [12:0] a, input logic [31:0] d,
                         input logic [3:0] b0, input logic [3:0] b1);
    wexp_t e;
    e.due = cyc + 1; e.a = a; e.d = d; e.b0 = b0; e.b1 = b1;
    wq.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] d);
    rexp_t e;
    e.due = cyc + 1; e.d = d;
    rq.push_back(e);
  endtask

  // Let combinational outputs settle, then retire whatever is due this cycle.
  task automatic observe();
    #1;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      wexp_t e;
      e = wq.pop_front();
      check_val("wr_en", {31'h0, sram_w_en}, 32'h0);
      check_val("wr_addr", {19'h0, sram_addr_out}, {19'h0, e.a});
      check_val("wr_data", sram_wdata, e.d);
      check_val("wr_b0csn", {28'h0, bank0_csn}, {28'h0, e.b0});
      check_val("wr_b1csn", {28'h0, bank1_csn}, {28'h0, e.b1});
      $display("cycle %0d WRITE addr=%h data=%h b0=%b b1=%b", cyc, sram_addr_out, sram_wdata, bank0_csn, bank1_csn);
    end else begin
      check_val("no_write", {31'h0, sram_w_en}, 32'h1);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      rexp_t r;
      r = rq.pop_front();
      check_val("rd_data", hrdata, r.d);
      $display("cycle %0d READ hrdata=%h", cyc, hrdata);
    end
  endtask

  task automatic check_idle_csn(input string tag);
    check_val({tag, "_b0"}, {28'h0, bank0_csn}, 32'hF);
    check_val({tag, "_b1"}, {28'h0, bank1_csn}, 32'hF);
  endtask

  initial begin
    hresetn = 1'b0;
    hready  = 1'b1;
    hburst  = 3'b000;
    hwdata  = 32'h0;
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    {sram_q7, sram_q6, sram_q5, sram_q4} = 32'h07060504;
    {sram_q3, sram_q2, sram_q1, sram_q0} = 32'h03020100;

    // Reset for 5 cycles, then check the idle outputs.
    repeat (5) next_cycle();
    hresetn = 1'b1;
    next_cycle();
    observe();
    check_idle_csn("rst");
    check_val("rst_wen", {31'h0, sram_w_en}, 32'h1);
    check_val("rst_hready", {31'h0, hready_resp}, 32'h1);
    check_val("rst_hresp", {30'h0, hresp}, 32'h0);
    check_val("rst_hrdata", hrdata, 32'h0);

    // Three back-to-back writes: a word, a byte to bank1 and a halfword to the upper lanes.
    next_cycle();
    drive(1'b1, NONSEQ, 1'b1, 32'h0000_0004, 3'd2);
    push_wr(13'h0001, 32'h000123AF, 4'b0000, 4'b1111);
    observe();
    next_cycle();
    hwdata = 32'h000123AF;
    drive(1'b1, NONSEQ, 1'b1, 32'h0000_8006, 3'd0);
    push_wr(13'h0001, 32'hA5A5A5A5, 4'b1111, 4'b1011);
    observe();
    check_val("pipe_hready1", {31'h0, hready_resp}, 32'h1);
    next_cycle();
    hwdata = 32'hA5A5A5A5;
    drive(1'b1, NONSEQ, 1'b1, 32'h0000_0002, 3'd1);
    push_wr(13'h0000, 32'h5A5A1234, 4'b0011, 4'b1111);
    observe();
    check_val("pipe_hready2", {31'h0, hready_resp}, 32'h1);
    next_cycle();
    hwdata = 32'h5A5A1234;
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    observe();

    // A word read from bank1, then a pipelined read from bank0
    next_cycle();
    drive(1'b1, NONSEQ, 1'b0, 32'h0000_8000, 3'd2);
    push_rd(32'h07060504);
    observe();
    check_val("rd1_b1csn", {28'h0, bank1_csn}, 32'h0);
    check_val("rd1_b0csn", {28'h0, bank0_csn}, 32'hF);
    check_val("rd1_addr", {19'h0, sram_addr_out}, 32'h0);
    next_cycle();
    drive(1'b1, NONSEQ, 1'b0, 32'h0000_0000, 3'd2);
    push_rd(32'h03020100);
    observe();
    check_val("rd2_b0csn", {28'h0, bank0_csn}, 32'h0);
    check_val("rd2_hready", {31'h0, hready_resp}, 32'h1);
    next_cycle();
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    observe();
    next_cycle();
    observe();
    check_val("rd_idle_hrdata", hrdata, 32'h0);

    // A write followed immediately by a read gives one stall cycle, and the read is then issued.
    next_cycle();
    drive(1'b1, NONSEQ, 1'b1, 32'h0000_0010, 3'd2);
    push_wr(13'h0004, 32'hDEADBEEF, 4'b0000, 4'b1111);
    observe();
    next_cycle();
    hwdata = 32'hDEADBEEF;
    drive(1'b1, NONSEQ, 1'b0, 32'h0000_0014, 3'd2);
    observe();
    check_val("stall_hready", {31'h0, hready_resp}, 32'h0);
    next_cycle();
    hwdata = 32'h0;
    push_rd(32'h03020100);
    observe();
    check_val("unstall_hready", {31'h0, hready_resp}, 32'h1);
    check_val("unstall_addr", {19'h0, sram_addr_out}, 32'h5);
    check_val("unstall_b0csn", {28'h0, bank0_csn}, 32'h0);
    next_cycle();
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    observe();

    // Aliased upper address bits, with a size above word treated as word.
    next_cycle();
    drive(1'b1, NONSEQ, 1'b1, 32'h0001_0008, 3'd3);
    push_wr(13'h0002, 32'h13572468, 4'b0000, 4'b1111);
    observe();
    next_cycle();
    hwdata = 32'h13572468;
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    observe();

    // BUSY, IDLE and deselected transfers produce no access.
    next_cycle();
    drive(1'b1, BUSY, 1'b1, 32'h0000_0020, 3'd2);
    observe();
    check_idle_csn("busy");
    next_cycle();
    drive(1'b1, IDLE, 1'b0, 32'h0000_0020, 3'd2);
    observe();
    check_idle_csn("busy_next");
    next_cycle();
    drive(1'b0, NONSEQ, 1'b0, 32'h0000_0024, 3'd2);
    observe();
    check_idle_csn("nosel");
    next_cycle();
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    observe();
    check_idle_csn("nosel_next");
    check_val("nosel_hrdata", hrdata, 32'h0);

    // A reset in the write address cycle cancels the write.
    next_cycle();
    hresetn = 1'b0;
    drive(1'b1, NONSEQ, 1'b1, 32'h0000_0030, 3'd2);
    #1;
    next_cycle();
    hresetn = 1'b1;
    hwdata  = 32'hCAFEF00D;
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
    observe();
    check_idle_csn("rstcancel");

    next_cycle();
    observe();
    check_val("wq_empty", wq.size(), 32'h0);
    check_val("rq_empty", rq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
AHB-Lite slave front end for a 64 KB on-chip SRAM. The SRAM is built as two banks, each four 8-bit-wide macros with 8K entries. The block decodes AHB transfers into SRAM chip selects, a word address, a write enable and write data. It returns a 32-bit read word from the selected bank. It sits between the AHB interconnect and the SRAM macro array.

Parameters:
None. Geometry is fixed: 2 banks x 4 byte lanes x 8K entries; haddr[15:0] is decoded.

Ports:
hclk  in  1  clock; all state updates on rising edge
hresetn  in  1  reset; synchronous, active-low
hsel  in  1  slave select
haddr  in  32  byte address; only [15:0] used
hwrite  in  1  1 = write, 0 = read
hsize  in  3  0 = byte, 1 = halfword, 2 = word; values above 2 treated as word
hburst  in  3  ignored; every beat is handled as an independent transfer
htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hready  in  1  bus ready from the interconnect
hwdata  in  32  write data, valid in the data phase
hready_resp  out  1  slave ready
hresp  out  2  response; constant OKAY (2'b00)
hrdata  out  32  read data
sram_q0..sram_q7  in  8 each  SRAM read data; q0..q3 = bank0 lanes 0..3, q4..q7 = bank1 lanes 0..3
sram_w_en  out  1  active-low write enable (0 = write, 1 = read/idle)
sram_addr_out  out  13  SRAM entry address (word index)
sram_wdata  out  32  write data; byte n goes to lane n of both banks
bank0_csn  out  4  active-low chip selects, bank0 lanes 3..0
bank1_csn  out  4  active-low chip selects, bank1 lanes 3..0

Behaviour:
- Address decode:
  - bank = haddr[15]
  - entry = haddr[14:2]
  - lane = haddr[1:0]
- Transfer request: req = hsel & hready & htrans[1]. IDLE and BUSY produce no access.
- Stall: stall = write data phase pending & req & ~hwrite (a read address phase collides with a pending write).
  - hready_resp = ~stall; otherwise hready_resp = 1.
  - An address phase is accepted only when req & ~stall.
- On every clock edge, registered state updates:
  - addr_r = haddr[15:0], size_r = hsize, bank_r = haddr[15]
  - wpend = accepted & hwrite
  - rpend = accepted & ~hwrite
  - If not accepted, wpend and rpend go to 0.
- Lane mask for a write:
  - byte: only lane addr[1:0]
  - halfword: lanes {1,0} if addr[1] = 0, lanes {3,2} if addr[1] = 1
  - word: all four lanes
- Write (data phase, wpend = 1):
  - sram_addr_out = addr_r[14:2]
  - sram_wdata = hwdata
  - sram_w_en = 0
  - Selected bank's csn = ~mask; other bank's csn = 4'b1111.
  - Write has priority over any concurrent address phase.
- Read (address phase, combinational when accepted & ~hwrite):
  - sram_addr_out = haddr[14:2], sram_w_en = 1
  - Selected bank's csn = 4'b0000 (all lanes); other bank's csn = 4'b1111.
  - SRAM returns data on the next cycle.
- Read data (data phase):
  - hrdata = bank_r ? {q7,q6,q5,q4} : {q3,q2,q1,q0}
  - hrdata is combinational from the sram_q inputs.
  - When no read is pending, hrdata = 0.
- Stalled read: no SRAM read is issued in the stall cycle. The master holds its address phase, and the read is accepted the following cycle.
- Idle (no write pending, no accepted read):
  - bank0_csn = bank1_csn = 4'b1111
  - sram_w_en = 1
  - sram_addr_out = haddr[14:2]
  - sram_wdata = hwdata
- Reset (hresetn = 0 at a clock edge):
  - wpend, rpend, addr_r, size_r and bank_r are all cleared.
  - Outputs therefore settle at idle values: both csn = 1111, sram_w_en = 1, hready_resp = 1, hresp = 00, hrdata = 0.
  - A reset during an address phase cancels that transfer; no SRAM write follows.
- Back-to-back writes are pipelined: the address phase of N+1 overlaps the data phase of N, with no wait states.
- hresp is never ERROR. Accesses with haddr[31:16] nonzero alias into the 64 KB space.

Test Plan:
- Reset 5 cycles, then idle → bank0_csn = bank1_csn = 1111, sram_w_en = 1, hready_resp = 1, hresp = 00.
- Word write haddr = 0x0004, hwdata = 0x000123AF (NONSEQ, hsize = 2) → in the data phase: sram_addr_out = 0x0001, sram_wdata = 0x000123AF, sram_w_en = 0, bank0_csn = 0000, bank1_csn = 1111.
- Byte write haddr = 0x8006 hsize = 0, then halfword write haddr = 0x0002 hsize = 1 → first data phase: bank1_csn = 1011, bank0_csn = 1111, addr = 0x0001. Second data phase: bank0_csn = 0011.
- Word read haddr = 0x8000, with sram_q0..q7 = 0..7 → address cycle: bank1_csn = 0000, sram_w_en = 1, sram_addr_out = 0. Next cycle: hrdata = 0x07060504. Read of 0x0000 → hrdata = 0x03020100.
- Write 0x0010 immediately followed by read 0x0014 → hready_resp = 0 for exactly one cycle, write performed in that cycle. The read is issued the next cycle with sram_addr_out = 0x0005.
- htrans = BUSY/IDLE or hsel = 0 with hready = 1 → no csn asserted. hresetn low in the write address cycle → no sram_w_en = 0 in the following cycle.
